// File: rtl/execute_stage_p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_pkg
// Purpose  : Shared aluOp codes, funct constants, ALU-op and FSM-state enums
//            and the ALU decode helper for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_rtype = 2'b10;

    localparam logic [5:0] c_funct_add   = 6'b100000;
    localparam logic [5:0] c_funct_sub   = 6'b100010;
    localparam logic [5:0] c_funct_and   = 6'b100100;
    localparam logic [5:0] c_funct_or    = 6'b100101;
    localparam logic [5:0] c_funct_slt   = 6'b101010;
    localparam logic [5:0] c_funct_sltu  = 6'b101011;
    localparam logic [5:0] c_funct_sll   = 6'b000000;
    localparam logic [5:0] c_funct_srl   = 6'b000010;
    localparam logic [5:0] c_funct_sra   = 6'b000011;
    localparam logic [5:0] c_funct_mfhi  = 6'b010000;
    localparam logic [5:0] c_funct_mflo  = 6'b010010;
    localparam logic [5:0] c_funct_mult  = 6'b011000;
    localparam logic [5:0] c_funct_multu = 6'b011001;

    // OP_NONE marks an unrecognised funct: the entry is still emitted with result 0
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_SLT  = 4'd4,  OP_SLTU = 4'd5,  OP_SLL  = 4'd6,  OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,  OP_MFHI = 4'd9,  OP_MFLO = 4'd10, OP_MUL  = 4'd11,
        OP_NONE = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic alu_op_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_op_e op;
        op = OP_ADD;
        case (alu_op)
            c_aluop_add: op = OP_ADD;
            c_aluop_sub: op = OP_SUB;
            c_aluop_rtype: begin
                case (funct)
                    c_funct_add:   op = OP_ADD;
                    c_funct_sub:   op = OP_SUB;
                    c_funct_and:   op = OP_AND;
                    c_funct_or:    op = OP_OR;
                    c_funct_slt:   op = OP_SLT;
                    c_funct_sltu:  op = OP_SLTU;
                    c_funct_sll:   op = OP_SLL;
                    c_funct_srl:   op = OP_SRL;
                    c_funct_sra:   op = OP_SRA;
                    c_funct_mfhi:  op = OP_MFHI;
                    c_funct_mflo:  op = OP_MFLO;
                    c_funct_mult:  op = OP_MUL;
                    c_funct_multu: op = OP_MUL;
                    default:       op = OP_NONE;
                endcase
            end
            default: op = OP_ADD;   // reserved code behaves as add
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_stage_p_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_p_if
// Purpose  : ID/EX input handshake plus EX/MEM output handshake of the
//            execute stage. master = surrounding pipeline, slave = stage.
// Revision : 1.0 - initial release
// ============================================================================
interface execute_stage_p_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        ctrl_aluOp;
    logic              ctrl_aluSrc;
    logic              ctrl_regDest;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   next_pc;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   branch_target;
    logic              zero;
    logic [REG_AW-1:0] write_register;
    logic              busy;

    modport master (
        output in_valid, ctrl_aluOp, ctrl_aluSrc, ctrl_regDest, rs_data, rt_data,
               imm_ext, next_pc, rt_addr, rd_addr, out_ready,
        input  in_ready, out_valid, alu_result, branch_target, zero, write_register, busy
    );

    modport slave (
        input  in_valid, ctrl_aluOp, ctrl_aluSrc, ctrl_regDest, rs_data, rt_data,
               imm_ext, next_pc, rt_addr, rd_addr, out_ready,
        output in_ready, out_valid, alu_result, branch_target, zero, write_register, busy
    );
endinterface
`default_nettype wire

// File: rtl/execute_stage_p_mult.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Iterative shift-add multiplier, XLEN steps per product. Signed
//            operands are multiplied as magnitudes and the sign fixed at the
//            end. done is a one-cycle strobe with product valid alongside it.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int XLEN = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic              is_signed,
    input  wire logic [XLEN-1:0]   op_a,
    input  wire logic [XLEN-1:0]   op_b,
    output logic                   done,
    output logic [2*XLEN-1:0]      product
);
    localparam int CW = $clog2(XLEN);

    logic              r_busy;
    logic              r_neg;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [2*XLEN-1:0] w_sum;

    assign w_abs_a = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign w_abs_b = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;
    assign w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign done    = r_busy && (r_cnt == CW'(XLEN - 1));
    // The last step's sum is presented directly so the caller captures it on the done edge
    assign product = r_neg ? -w_sum : w_sum;

    // Operand load on start, then one partial product accumulated per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_neg    <= is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
        end else if (r_busy) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/execute_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_p
// Purpose  : Pipelined EX stage: ALU decode/execute, branch-target adder,
//            RegDst mux, registered EX/MEM slot with valid/ready on both
//            sides, and a sequential multiplier feeding internal HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage_p
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  wire logic    clk,
    input  wire logic    reset,
    execute_stage_p_if.slave bus
);
    state_e              r_state;
    state_e              w_state_next;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_alu_result;
    logic [XLEN-1:0]     r_branch_target;
    logic                r_zero;
    logic [REG_AW-1:0]   r_write_register;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_mul_bt;

    alu_op_e             w_op;
    logic                w_slot_free;
    logic                w_in_ready;
    logic                w_mul_start;
    logic                w_mul_done;
    logic                w_single_load;
    logic                w_done_load;
    logic [XLEN-1:0]     w_op_b;
    logic [4:0]          w_shamt;
    logic [XLEN-1:0]     w_bt;
    logic [XLEN-1:0]     w_result;
    logic [REG_AW-1:0]   w_dest;
    logic [2*XLEN-1:0]   w_product;

    assign w_op        = decode_op(bus.ctrl_aluOp, bus.imm_ext[5:0]);
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_op_b      = bus.ctrl_aluSrc ? bus.imm_ext : bus.rt_data;
    assign w_shamt     = bus.imm_ext[10:6];
    assign w_bt        = bus.next_pc + (bus.imm_ext << 2);
    assign w_dest      = bus.ctrl_regDest ? bus.rd_addr : bus.rt_addr;

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.alu_result     = r_alu_result;
    assign bus.branch_target  = r_branch_target;
    assign bus.zero           = r_zero;
    assign bus.write_register = r_write_register;
    assign bus.busy           = (r_state == S_MUL);

    seq_multiplier #(.XLEN(XLEN)) u_mult (
        .clk       (clk),
        .reset     (reset),
        .start     (w_mul_start),
        .is_signed (bus.imm_ext[5:0] == c_funct_mult),
        .op_a      (bus.rs_data),
        .op_b      (bus.rt_data),
        .done      (w_mul_done),
        .product   (w_product)
    );

    // Single-cycle ALU result for the instruction currently offered
    always_comb begin
        w_result = '0;
        case (w_op)
            OP_ADD:  w_result = bus.rs_data + w_op_b;
            OP_SUB:  w_result = bus.rs_data - w_op_b;
            OP_AND:  w_result = bus.rs_data & w_op_b;
            OP_OR:   w_result = bus.rs_data | w_op_b;
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(bus.rs_data) < $signed(w_op_b))};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (bus.rs_data < w_op_b)};
            OP_SLL:  w_result = bus.rt_data << w_shamt;
            OP_SRL:  w_result = bus.rt_data >> w_shamt;
            OP_SRA:  w_result = XLEN'($signed(bus.rt_data) >>> w_shamt);
            OP_MFHI: w_result = r_hi;
            OP_MFLO: w_result = r_lo;
            default: w_result = '0;
        endcase
    end

    // Stage FSM: accept gating, multiply start and deferred slot load
    always_comb begin
        w_state_next  = r_state;
        w_in_ready    = 1'b0;
        w_mul_start   = 1'b0;
        w_done_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = w_slot_free;
                if (bus.in_valid && w_slot_free && (w_op == OP_MUL)) begin
                    w_mul_start  = 1'b1;
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_slot_free) begin
                    w_done_load  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_single_load = bus.in_valid && w_in_ready && (w_op != OP_MUL);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // HI/LO written only when a product completes; branch target of a multiply held until its entry issues
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_mul_bt <= '0;
        end else begin
            if (w_mul_done) begin
                r_hi <= w_product[2*XLEN-1:XLEN];
                r_lo <= w_product[XLEN-1:0];
            end
            if (w_mul_start) begin
                r_mul_bt <= w_bt;
            end
        end
    end

    // EX/MEM output slot: load, drain, or hold under back-pressure
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_alu_result     <= '0;
            r_branch_target  <= '0;
            r_zero           <= 1'b0;
            r_write_register <= '0;
        end else if (w_single_load) begin
            r_out_valid      <= 1'b1;
            r_alu_result     <= w_result;
            r_branch_target  <= w_bt;
            r_zero           <= (bus.ctrl_aluOp == c_aluop_sub) && (bus.rs_data == bus.rt_data);
            r_write_register <= w_dest;
        end else if (w_done_load) begin
            r_out_valid      <= 1'b1;
            r_alu_result     <= '0;
            r_branch_target  <= r_mul_bt;
            r_zero           <= 1'b0;
            r_write_register <= '0;
        end else if (bus.out_ready) begin
            r_out_valid      <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_execute_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage_p
// Purpose  : Self-checking bench for execute_stage_p: directed scenarios plus
//            random traffic scored against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage_p;

    typedef struct {
        logic [31:0] res;
        logic [31:0] bt;
        logic        z;
        logic [4:0]  wr;
    } ent_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    ent_t q[$];
    ent_t saved;
    logic pend;
    logic accepted;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [5:0]  ftab [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00,
                               6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19};

    execute_stage_p_if #(.XLEN(32), .REG_AW(5)) bus ();

    execute_stage_p #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level model: what the stage must eventually emit for this instruction
    task automatic predict(output ent_t e);
        logic [31:0] b;
        logic [4:0]  sh;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        b    = bus.ctrl_aluSrc ? bus.imm_ext : bus.rt_data;
        sh   = bus.imm_ext[10:6];
        e.bt = bus.next_pc + (bus.imm_ext << 2);
        e.z  = (bus.ctrl_aluOp == 2'b01) && (bus.rs_data == bus.rt_data);
        e.wr = bus.ctrl_regDest ? bus.rd_addr : bus.rt_addr;
        sa   = $signed(bus.rs_data);
        sb   = $signed(bus.rt_data);
        case (bus.ctrl_aluOp)
            2'b01: e.res = bus.rs_data - b;
            2'b10: begin
                case (bus.imm_ext[5:0])
                    6'h20: e.res = bus.rs_data + b;
                    6'h22: e.res = bus.rs_data - b;
                    6'h24: e.res = bus.rs_data & b;
                    6'h25: e.res = bus.rs_data | b;
                    6'h2A: e.res = ($signed(bus.rs_data) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: e.res = (bus.rs_data < b) ? 32'd1 : 32'd0;
                    6'h00: e.res = bus.rt_data << sh;
                    6'h02: e.res = bus.rt_data >> sh;
                    6'h03: e.res = 32'(sb >>> sh);
                    6'h10: e.res = m_hi;
                    6'h12: e.res = m_lo;
                    6'h18, 6'h19: begin
                        if (bus.imm_ext[0]) p = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};
                        else                p = 64'(sa * sb);
                        m_hi  = p[63:32];
                        m_lo  = p[31:0];
                        e.res = 32'd0;
                        e.wr  = 5'd0;
                    end
                    default: e.res = 32'd0;
                endcase
            end
            default: e.res = bus.rs_data + b;
        endcase
    endtask

    // One clock: score the slot and the accept for this cycle, then advance to the next negedge
    task automatic tick();
        ent_t e;
        #1;
        if (reset) begin
            q.delete();
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            pend     = 1'b0;
            accepted = 1'b0;
        end else begin
            if (pend) begin
                check("hold_valid",  bus.out_valid,      1);
                check("hold_result", bus.alu_result,     saved.res);
                check("hold_bt",     bus.branch_target,  saved.bt);
                check("hold_zero",   bus.zero,           saved.z);
                check("hold_wr",     bus.write_register, saved.wr);
                pend = 1'b0;
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_entry", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("sb_result", bus.alu_result,     e.res);
                        check("sb_bt",     bus.branch_target,  e.bt);
                        check("sb_zero",   bus.zero,           e.z);
                        check("sb_wr",     bus.write_register, e.wr);
                    end
                end else begin
                    saved.res = bus.alu_result;
                    saved.bt  = bus.branch_target;
                    saved.z   = bus.zero;
                    saved.wr  = bus.write_register;
                    pend      = 1'b1;
                end
            end
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) begin
                predict(e);
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [1:0] op, input logic src, input logic rdsel,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] imm, input logic [31:0] npc,
                             input logic [4:0] rta, input logic [4:0] rda);
        bus.ctrl_aluOp   = op;
        bus.ctrl_aluSrc  = src;
        bus.ctrl_regDest = rdsel;
        bus.rs_data      = rs;
        bus.rt_data      = rt;
        bus.imm_ext      = imm;
        bus.next_pc      = npc;
        bus.rt_addr      = rta;
        bus.rd_addr      = rda;
    endtask

    // Offer the set instruction for one cycle and check the registered result
    task automatic issue(input string tag, input logic [31:0] exp);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, bus.out_valid, 1);
        check(tag, bus.alu_result, exp);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !bus.in_ready; i++) tick();
        check("ready_timeout", bus.in_ready, 1);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_instr();
        int          r;
        logic [31:0] x;
        r = $urandom_range(0, 9);
        bus.ctrl_aluOp   = (r < 2) ? 2'b00 : (r == 2) ? 2'b01 : (r == 3) ? 2'b11 : 2'b10;
        bus.ctrl_aluSrc  = (bus.ctrl_aluOp == 2'b10) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
        bus.ctrl_regDest = 1'($urandom_range(0, 1));
        bus.rs_data      = rand_opnd();
        bus.rt_data      = ($urandom_range(0, 4) == 0) ? bus.rs_data : rand_opnd();
        x                = $urandom();
        bus.imm_ext      = {{16{x[15]}}, x[15:0]};
        if (bus.ctrl_aluOp == 2'b10) begin
            bus.imm_ext[5:0] = ($urandom_range(0, 13) == 13) ? 6'($urandom()) : ftab[$urandom_range(0, 12)];
        end
        bus.next_pc = $urandom() & 32'hFFFF_FFFC;
        bus.rt_addr = 5'($urandom());
        bus.rd_addr = 5'($urandom());
    endtask

    initial begin
        logic hold;
        n_vec = 0;
        n_err = 0;
        pend  = 1'b0;
        accepted = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_instr(2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result",    bus.alu_result, 0);
        check("rst_bt",        bus.branch_target, 0);
        check("rst_zero",      bus.zero, 0);
        check("rst_wr",        bus.write_register, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_in_ready",  bus.in_ready, 1);

        // add, beq compare, sra, slt, sltu
        set_instr(2'b10, 1'b0, 1'b1, 32'd5, 32'd7, 32'h20, 32'h0, 5'd2, 5'd3);
        issue("add", 32'd12);
        check("add_wr", bus.write_register, 3);
        set_instr(2'b01, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'hFFFF_FFFE, 32'h100, 5'd9, 5'd4);
        issue("beq_result", 32'd0);
        check("beq_zero", bus.zero, 1);
        check("beq_bt",   bus.branch_target, 32'hF8);
        check("beq_wr",   bus.write_register, 9);
        set_instr(2'b10, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 32'h103, 32'h0, 5'd1, 5'd6);
        issue("sra", 32'hF800_0000);
        set_instr(2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h2A, 32'h0, 5'd1, 5'd6);
        issue("slt", 32'd1);
        set_instr(2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h2B, 32'h0, 5'd1, 5'd6);
        issue("sltu", 32'd0);

        // Signed multiply: 32 busy cycles, DONE, then the entry issues
        set_instr(2'b10, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'h18, 32'h40, 5'd1, 5'd6);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("mult_busy",     bus.busy, 1);
            check("mult_in_ready", bus.in_ready, 0);
            tick();
        end
        check("mult_busy_end", bus.busy, 0);
        check("mult_not_yet",  bus.out_valid, 0);
        tick();
        check("mult_valid",  bus.out_valid, 1);
        check("mult_result", bus.alu_result, 0);
        check("mult_wr",     bus.write_register, 0);
        set_instr(2'b10, 1'b0, 1'b1, 32'd0, 32'd0, 32'h10, 32'h0, 5'd1, 5'd6);
        issue("mfhi_s", 32'hFFFF_FFFF);
        set_instr(2'b10, 1'b0, 1'b1, 32'd0, 32'd0, 32'h12, 32'h0, 5'd1, 5'd6);
        issue("mflo_s", 32'hFFFF_FFF4);

        // Unsigned multiply
        set_instr(2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'h19, 32'h0, 5'd1, 5'd6);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_ready();
        set_instr(2'b10, 1'b0, 1'b1, 32'd0, 32'd0, 32'h10, 32'h0, 5'd1, 5'd6);
        issue("mfhi_u", 32'd1);
        set_instr(2'b10, 1'b0, 1'b1, 32'd0, 32'd0, 32'h12, 32'h0, 5'd1, 5'd6);
        issue("mflo_u", 32'hFFFF_FFFE);
        tick();

        // Back-pressure: second instruction held, not lost
        bus.out_ready = 1'b0;
        set_instr(2'b10, 1'b0, 1'b1, 32'd1, 32'd1, 32'h20, 32'h0, 5'd1, 5'd6);
        issue("bp_first", 32'd2);
        set_instr(2'b10, 1'b0, 1'b1, 32'd3, 32'd5, 32'h25, 32'h0, 5'd1, 5'd7);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("bp_in_ready", bus.in_ready, 0);
            tick();
            check("bp_stable", bus.alu_result, 2);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("bp_second_valid", bus.out_valid, 1);
        check("bp_second", bus.alu_result, 7);
        tick();

        // Reset in the middle of a multiply
        set_instr(2'b10, 1'b0, 1'b1, 32'd7, 32'd9, 32'h18, 32'h0, 5'd1, 5'd6);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid",    bus.out_valid, 0);
        check("abort_busy",     bus.busy, 0);
        check("abort_in_ready", bus.in_ready, 1);
        set_instr(2'b10, 1'b0, 1'b1, 32'd0, 32'd0, 32'h10, 32'h0, 5'd1, 5'd6);
        issue("abort_hi", 32'd0);
        set_instr(2'b10, 1'b0, 1'b1, 32'd0, 32'd0, 32'h12, 32'h0, 5'd1, 5'd6);
        issue("abort_lo", 32'd0);
        tick();

        // Random traffic against the model; an unaccepted instruction stays offered
        for (int c = 0; c < 3000; c++) begin
            hold = bus.in_valid && !accepted;
            if (!hold) begin
                rand_instr();
                bus.in_valid = ($urandom_range(0, 9) < 7);
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        // Drain
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && (q.size() != 0 || bus.out_valid); i++) tick();
        check("drain_queue", q.size(), 0);
        check("drain_valid", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
